// File: rtl/cpack_pkg.sv
// Shared C-Pack definitions: code types, prefix widths and code length helpers.
package cpack_pkg;

  typedef enum logic [2:0] {
    CODE_ZZZZ = 3'd0,
    CODE_XXXX = 3'd1,
    CODE_MMMM = 3'd2,
    CODE_MMXX = 3'd3,
    CODE_ZZZX = 3'd4,
    CODE_MMMX = 3'd5
  } code_t;

  typedef logic [1:0] cnt_t;

  // ZZZZ, XXXX and MMMM use the short prefix; the rest use the long one
  localparam int PFX_SHORT = 2;
  localparam int PFX_LONG  = 4;

  localparam int LEN_ZZZZ = PFX_SHORT;
  localparam int LEN_XXXX = PFX_SHORT + 32;
  localparam int LEN_ZZZX = PFX_LONG + 8;

  function automatic logic [5:0] code_len(code_t t, int idx_w);
    int len;
    case (t)
      CODE_ZZZZ: len = LEN_ZZZZ;
      CODE_XXXX: len = LEN_XXXX;
      CODE_MMMM: len = PFX_SHORT + idx_w;
      CODE_MMXX: len = PFX_LONG + idx_w + 16;
      CODE_ZZZX: len = LEN_ZZZX;
      CODE_MMMX: len = PFX_LONG + idx_w + 8;
      default:   len = 0;
    endcase
    return 6'(len);
  endfunction

endpackage

// File: rtl/cpack_match_select.sv
// Picks the highest match count across all entries; ties resolve to the lowest index.
module cpack_match_select
  import cpack_pkg::*;
#(
  parameter int DICT_DEPTH = 16,
  parameter int IDX_W      = $clog2(DICT_DEPTH)
) (
  input  logic [DICT_DEPTH-1:0][1:0] cnt,
  output cnt_t                       best_cnt,
  output logic [IDX_W-1:0]           best_idx
);

  // strict compare keeps the earlier (lower) index on equal counts
  always_comb begin
    best_cnt = cnt[0];
    best_idx = '0;
    for (int e = 1; e < DICT_DEPTH; e++) begin
      if (cnt[e] > best_cnt) begin
        best_cnt = cnt[e];
        best_idx = IDX_W'(e);
      end
    end
  end

endmodule

// File: rtl/word_decoder.sv
// Per-entry match counter: only MSB-first contiguous byte matches count.
module word_decoder
  import cpack_pkg::*;
(
  input  logic [3:0] cmp,
  output cnt_t       cnt
);

  always_comb begin
    case (cmp)
      4'b1111: cnt = 2'd3;
      4'b1110: cnt = 2'd2;
      4'b1100: cnt = 2'd1;
      default: cnt = 2'd0;
    endcase
  end

endmodule

// File: rtl/cpack_match_ctrl.sv
// C-Pack word matcher: dictionary compare at accept, per-entry decode in S1,
// code selection into the S2 output registers.
module cpack_match_ctrl
  import cpack_pkg::*;
#(
  parameter int DICT_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [31:0]                   i_word,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [2:0]                    o_code_type,
  output logic [$clog2(DICT_DEPTH)-1:0] o_dict_idx,
  output logic [31:0]                   o_payload,
  output logic [5:0]                    o_code_len
);

  localparam int IDX_W = $clog2(DICT_DEPTH);

  logic [31:0]                 dict_word [DICT_DEPTH];
  logic [DICT_DEPTH-1:0]       dict_vld;
  logic [IDX_W-1:0]            wr_ptr;
  logic [IDX_W-1:0]            push_idx;
  logic [DICT_DEPTH-1:0][3:0]  cmp;
  logic                        full_hit;
  logic                        push;
  logic                        accept;
  logic                        advance;

  logic                        s1_valid;
  logic [31:0]                 s1_word;
  logic [DICT_DEPTH-1:0][3:0]  s1_cmp;
  logic                        s2_valid;

  logic [DICT_DEPTH-1:0][1:0]  cnt;
  cnt_t                        best_cnt;
  logic [IDX_W-1:0]            best_idx;
  code_t                       sel_type;
  logic [IDX_W-1:0]            sel_idx;
  logic [31:0]                 sel_payload;

  assign advance = !s2_valid || i_ready;
  assign o_ready = advance || !s1_valid;
  assign accept  = i_valid && o_ready;
  assign o_valid = s2_valid;

  // a flush in the same cycle makes the word see an empty dictionary
  always_comb begin
    full_hit = 1'b0;
    for (int e = 0; e < DICT_DEPTH; e++) begin
      for (int b = 0; b < 4; b++) begin
        cmp[e][b] = dict_vld[e] && !i_flush &&
                    (i_word[8*b +: 8] == dict_word[e][8*b +: 8]);
      end
      if (cmp[e] == 4'b1111) full_hit = 1'b1;
    end
  end

  assign push     = accept && (i_word != 32'd0) && (i_word[31:8] != 24'd0) && !full_hit;
  assign push_idx = i_flush ? '0 : wr_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dict_vld <= '0;
      wr_ptr   <= '0;
    end else begin
      if (i_flush) begin
        dict_vld <= '0;
        wr_ptr   <= '0;
      end
      if (push) begin
        dict_vld[push_idx] <= 1'b1;
        wr_ptr             <= push_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_reset) dict_word[push_idx] <= i_word;
  end

  for (genvar e = 0; e < DICT_DEPTH; e++) begin : g_dec
    word_decoder u_dec (
      .cmp (s1_cmp[e]),
      .cnt (cnt[e])
    );
  end

  cpack_match_select #(
    .DICT_DEPTH (DICT_DEPTH),
    .IDX_W      (IDX_W)
  ) u_sel (
    .cnt      (cnt),
    .best_cnt (best_cnt),
    .best_idx (best_idx)
  );

  always_comb begin
    sel_type    = CODE_XXXX;
    sel_idx     = '0;
    sel_payload = s1_word;
    if (s1_word == 32'd0) begin
      sel_type    = CODE_ZZZZ;
      sel_payload = '0;
    end else if (s1_word[31:8] == 24'd0) begin
      sel_type    = CODE_ZZZX;
      sel_payload = {24'd0, s1_word[7:0]};
    end else begin
      case (best_cnt)
        2'd3: begin
          sel_type    = CODE_MMMM;
          sel_idx     = best_idx;
          sel_payload = '0;
        end
        2'd2: begin
          sel_type    = CODE_MMMX;
          sel_idx     = best_idx;
          sel_payload = {24'd0, s1_word[7:0]};
        end
        2'd1: begin
          sel_type    = CODE_MMXX;
          sel_idx     = best_idx;
          sel_payload = {16'd0, s1_word[15:0]};
        end
        default: ;
      endcase
    end
  end

  // S1 may still fill while S2 is stalled, as long as it is empty
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      o_code_type <= CODE_ZZZZ;
      o_dict_idx  <= '0;
      o_payload   <= '0;
      o_code_len  <= '0;
    end else begin
      s1_valid <= accept || (s1_valid && !advance);
      if (accept) begin
        s1_word <= i_word;
        s1_cmp  <= cmp;
      end
      if (advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          o_code_type <= sel_type;
          o_dict_idx  <= sel_idx;
          o_payload   <= sel_payload;
          o_code_len  <= code_len(sel_type, IDX_W);
        end
      end
    end
  end

endmodule

// File: tb/tb_cpack_match_ctrl.sv
// Directed bench for cpack_match_ctrl with hand-computed expected codes.
module tb_cpack_match_ctrl;
  import cpack_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_ready;
  logic        o_ready, o_valid;
  logic [31:0] i_word, o_payload;
  logic [2:0]  o_code_type;
  logic [3:0]  o_dict_idx;
  logic [5:0]  o_code_len;

  cpack_match_ctrl #(.DICT_DEPTH(16)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_word      (i_word),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_code_type (o_code_type),
    .o_dict_idx  (o_dict_idx),
    .o_payload   (o_payload),
    .o_code_len  (o_code_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [3:0]  idx;
    logic [31:0] p;
    logic [5:0]  len;
  } code_rec_t;

  typedef struct {
    logic [31:0] w;
    logic        fl;
    logic [2:0]  t;
    logic [3:0]  idx;
    logic [31:0] p;
    logic [5:0]  len;
  } vec_t;

  code_rec_t q[$];
  int n_vec = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (!i_reset && o_valid && i_ready)
      q.push_back('{o_code_type, o_dict_idx, o_payload, o_code_len});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // called and returns just after a rising edge
  task automatic send(input logic [31:0] w, input logic fl);
    bit done;
    done    = 1'b0;
    i_valid = 1'b1;
    i_word  = w;
    i_flush = fl;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = o_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 64'(done), 64'd1);
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic expect_code(input string tag, input logic [2:0] t, input logic [3:0] idx,
                             input logic [31:0] p, input logic [5:0] len);
    code_rec_t r;
    for (int c = 0; c < 12 && q.size() == 0; c++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() == 0) begin
      check({tag, "_timeout"}, 64'(q.size()), 64'd1);
    end else begin
      r = q.pop_front();
      check({tag, "_type"}, 64'(r.t),   64'(t));
      check({tag, "_idx"},  64'(r.idx), 64'(idx));
      check({tag, "_pay"},  64'(r.p),   64'(p));
      check({tag, "_len"},  64'(r.len), 64'(len));
    end
  endtask

  vec_t tab_a[5] = '{
    '{32'h12345678, 1'b0, CODE_XXXX, 4'd0, 32'h12345678, 6'd34},
    '{32'h12345678, 1'b0, CODE_MMMM, 4'd0, 32'h00000000, 6'd6},
    '{32'h123456FF, 1'b0, CODE_MMMX, 4'd0, 32'h000000FF, 6'd16},
    '{32'h1234AAAA, 1'b0, CODE_MMXX, 4'd0, 32'h0000AAAA, 6'd24},
    '{32'hFF34FF78, 1'b0, CODE_XXXX, 4'd0, 32'hFF34FF78, 6'd34}
  };

  vec_t tab_b[9] = '{
    '{32'h01000001, 1'b1, CODE_XXXX, 4'd0, 32'h01000001, 6'd34},
    '{32'hAABB1234, 1'b0, CODE_XXXX, 4'd0, 32'hAABB1234, 6'd34},
    '{32'h02000003, 1'b0, CODE_XXXX, 4'd0, 32'h02000003, 6'd34},
    '{32'hAABBCC11, 1'b0, CODE_MMXX, 4'd1, 32'h0000CC11, 6'd24},
    '{32'h04000004, 1'b0, CODE_XXXX, 4'd0, 32'h04000004, 6'd34},
    '{32'h05000005, 1'b0, CODE_XXXX, 4'd0, 32'h05000005, 6'd34},
    '{32'h06000006, 1'b0, CODE_XXXX, 4'd0, 32'h06000006, 6'd34},
    '{32'hAABBCC22, 1'b0, CODE_MMMX, 4'd3, 32'h00000022, 6'd16},
    '{32'hAABBCC00, 1'b0, CODE_MMMX, 4'd3, 32'h00000000, 6'd16}
  };

  logic [31:0] xw[3] = '{32'h77000001, 32'h77000002, 32'h77000003};

  initial begin
    logic [31:0] w;
    logic [2:0]  s_t;
    logic [3:0]  s_idx;
    logic [31:0] s_p;
    logic [5:0]  s_len;
    bit          snap, acc;
    int          nacc;

    i_reset = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_word  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(o_valid),     64'd0);
    check("rst_type",  64'(o_code_type), 64'd0);
    check("rst_idx",   64'(o_dict_idx),  64'd0);
    check("rst_pay",   64'(o_payload),   64'd0);
    check("rst_len",   64'(o_code_len),  64'd0);
    check("rst_ready", 64'(o_ready),     64'd1);
    @(posedge clk); #1;

    // zero words, plus two-cycle latency
    send(32'h00000000, 1'b0);
    @(negedge clk);
    check("lat_s1", 64'(o_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_s2", 64'(o_valid), 64'd1);
    @(posedge clk); #1;
    expect_code("zzzz", CODE_ZZZZ, 4'd0, 32'h0, 6'd2);
    send(32'h000000AB, 1'b0);
    expect_code("zzzx", CODE_ZZZX, 4'd0, 32'hAB, 6'd12);
    check("t1_wrptr", 64'(dut.wr_ptr), 64'd0);

    // back-to-back repeat, partial matches, non-contiguous match
    foreach (tab_a[i]) send(tab_a[i].w, tab_a[i].fl);
    foreach (tab_a[i])
      expect_code($sformatf("a%0d", i), tab_a[i].t, tab_a[i].idx, tab_a[i].p, tab_a[i].len);
    check("a_wrptr", 64'(dut.wr_ptr), 64'd4);

    // flush-started block, equal cnt2 at entries 3 and 7
    foreach (tab_b[i]) send(tab_b[i].w, tab_b[i].fl);
    foreach (tab_b[i])
      expect_code($sformatf("b%0d", i), tab_b[i].t, tab_b[i].idx, tab_b[i].p, tab_b[i].len);
    check("b_wrptr", 64'(dut.wr_ptr), 64'd9);

    // wrap: 17 distinct words, the 17th replaces entry 0
    for (int i = 0; i < 17; i++) begin
      w = {8'(8'h10 + i), 8'hC3, 8'h5A, 8'(i)};
      send(w, i == 0);
    end
    for (int i = 0; i < 17; i++) begin
      w = {8'(8'h10 + i), 8'hC3, 8'h5A, 8'(i)};
      expect_code($sformatf("w%0d", i), CODE_XXXX, 4'd0, w, 6'd34);
    end
    check("wrap_wrptr", 64'(dut.wr_ptr), 64'd1);
    check("wrap_e0", 64'(dut.dict_word[0]), 64'h20C35A10);
    send(32'h10C35A00, 1'b0);
    expect_code("resend_w0", CODE_XXXX, 4'd0, 32'h10C35A00, 6'd34);
    check("resend_wrptr", 64'(dut.wr_ptr), 64'd2);
    send(32'h13C35A03, 1'b1);
    expect_code("flush_acc", CODE_XXXX, 4'd0, 32'h13C35A03, 6'd34);
    check("flush_wrptr", 64'(dut.wr_ptr), 64'd1);
    check("flush_vld", 64'(dut.dict_vld), 64'h0001);

    // backpressure
    snap    = 1'b0;
    nacc    = 0;
    s_t     = '0;
    s_idx   = '0;
    s_p     = '0;
    s_len   = '0;
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_word  = xw[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (o_valid && !snap) begin
        snap  = 1'b1;
        s_t   = o_code_type;
        s_idx = o_dict_idx;
        s_p   = o_payload;
        s_len = o_code_len;
      end
      acc = o_ready;
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        i_word = xw[nacc % 3];
      end
    end
    @(negedge clk);
    check("stall_accepts", 64'(nacc), 64'd2);
    check("stall_ready", 64'(o_ready), 64'd0);
    check("stall_valid", 64'(o_valid), 64'd1);
    check("stall_seen", 64'(snap), 64'd1);
    check("stall_hold", {o_code_type, o_dict_idx, o_payload, o_code_len},
          {s_t, s_idx, s_p, s_len});
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    expect_code("stall_x0", CODE_XXXX, 4'd0, 32'h77000001, 6'd34);
    expect_code("stall_x1", CODE_MMMX, 4'd1, 32'h00000002, 6'd16);

    // reset mid-stream
    i_valid = 1'b1;
    i_word  = 32'h88000001;
    repeat (3) begin
      @(posedge clk); #1;
    end
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    check("mrst_valid", 64'(o_valid), 64'd0);
    check("mrst_vld", 64'(dut.dict_vld), 64'd0);
    check("mrst_wrptr", 64'(dut.wr_ptr), 64'd0);
    q.delete();
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mrst_drop", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
